ioctl_stream_tx: RTL and testbench
==================================

IOCTL_STREAM_TX -- requirements
Module: ioctl_stream_tx

Interface
REQ-001 SHALL have parameter MIN_GAP, default 2, giving the minimum number of clocks from an ioctl_wr pulse to the next one.
REQ-002 SHALL have parameter PAD_BYTE, default 8'hFF, giving the high byte filled into the final word of an odd-length image.
REQ-003 SHALL have port clk_sys, input, 1 bit: the single clock.
REQ-004 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle request to begin a transfer.
REQ-006 SHALL have port abort, input, 1 bit: request to stop the transfer in progress.
REQ-007 SHALL have port length, input, 25 bits: image size in bytes, sampled when start is accepted.
REQ-008 SHALL have port src_valid, input, 1 bit: source byte is available.
REQ-009 SHALL have port src_data, input, 8 bits: the source byte.
REQ-010 SHALL have port src_ready, output, 1 bit: this block accepts the byte this cycle.
REQ-011 SHALL have port ioctl_download, output, 1 bit: a transfer is active.
REQ-012 SHALL have port ioctl_wr, output, 1 bit: one-cycle word write strobe.
REQ-013 SHALL have port ioctl_addr, output, 25 bits: byte address of the word, always even.
REQ-014 SHALL have port ioctl_dout, output, 16 bits: data word; [7:0] holds the byte at the even address, [15:8] the byte at the odd address.
REQ-015 SHALL have port ioctl_wait, input, 1 bit: the receiver is busy; no new ioctl_wr may be issued.
REQ-016 SHALL have port busy, output, 1 bit: the state is not IDLE.
REQ-017 SHALL have port done, output, 1 bit: one-cycle pulse when a transfer ends.
REQ-018 SHALL have port aborted, output, 1 bit: valid together with done; high if the transfer ended by abort.

Function
REQ-019 States SHALL be IDLE, FILL_LO, FILL_HI, WRITE, HOLD and TAIL.
REQ-020 IDLE: start SHALL latch length, clear ioctl_addr to 0, set ioctl_download=1 from the next cycle, and go to FILL_LO; if length=0 it SHALL go to TAIL instead.
REQ-021 start SHALL be ignored when busy=1.
REQ-022 src_ready SHALL equal 1 only in FILL_LO and FILL_HI; a byte is taken on src_valid&src_ready.
REQ-023 FILL_LO: the taken byte SHALL go to ioctl_dout[7:0]. If it is the last byte, ioctl_dout[15:8] SHALL be set to PAD_BYTE and the state SHALL go to WRITE; otherwise it SHALL go to FILL_HI.
REQ-024 FILL_HI: the taken byte SHALL go to ioctl_dout[15:8] and the state SHALL go to WRITE.
REQ-025 WRITE SHALL last exactly 1 cycle with ioctl_wr=1, then go to HOLD; ioctl_addr and ioctl_dout SHALL be stable from WRITE until HOLD exits.
REQ-026 HOLD SHALL exit only when at least MIN_GAP cycles have passed since WRITE AND ioctl_wait=0; ioctl_wait SHALL be ignored in the first cycle of HOLD.
REQ-027 On HOLD exit: ioctl_addr SHALL increase by 2, the byte counter SHALL decrease by the bytes consumed, and the state SHALL go to FILL_LO if bytes remain, else to TAIL.
REQ-028 TAIL SHALL keep ioctl_download=1 for one more cycle, then drop it, pulse done, and return to IDLE.
REQ-029 abort in FILL_LO or FILL_HI SHALL discard any partial word and go to TAIL with aborted set.
REQ-030 abort in WRITE or HOLD SHALL let the current word complete, then go to TAIL with aborted set.
REQ-031 abort in IDLE or TAIL SHALL have no effect.
REQ-032 If start and abort are both high in IDLE, start SHALL win.
REQ-033 Address arithmetic SHALL be modulo 2^25; wrap-around SHALL not be detected.
REQ-034 The byte count SHALL never underflow.

Reset
REQ-035 When reset_n=0 at a clock edge, the block SHALL enter IDLE with ioctl_download=0, ioctl_wr=0, ioctl_addr=0, ioctl_dout=0, src_ready=0, busy=0, done=0, aborted=0, and the counters cleared.
REQ-036 Reset during a transfer SHALL drop ioctl_download on the next cycle and SHALL NOT pulse done.

Configuration
REQ-037 With IOCTL_STREAM_TX_CHECKSUM_EN defined, the block SHALL add output checksum (16 bits): the modulo-2^16 sum of all source bytes taken, excluding padding, cleared on start and valid when done pulses.
REQ-038 Without IOCTL_STREAM_TX_CHECKSUM_EN, the checksum port SHALL be absent and no summing logic SHALL be built.

Verification
REQ-039 length=4, bytes 11,22,33,44, ioctl_wait=0 -> two ioctl_wr pulses: addr 0 / dout 16'h2211, then addr 2 / dout 16'h4433; done pulses once with aborted=0.
REQ-040 length=3, bytes AA,BB,CC -> second word is addr 2 / dout 16'hFFCC; checksum=16'h0231 when IOCTL_STREAM_TX_CHECKSUM_EN is defined.
REQ-041 ioctl_wait held high for 10 cycles after the first ioctl_wr -> second ioctl_wr comes no earlier than 12 cycles after the first; dout is unchanged throughout.
REQ-042 length=0 -> ioctl_download high for exactly 2 cycles, no ioctl_wr, one done pulse.
REQ-043 abort in FILL_HI after 5 of 8 bytes -> exactly 2 writes (addr 0 and 2), then done with aborted=1.
REQ-044 reset_n low for 1 cycle while in HOLD -> IDLE and ioctl_download=0 on the next cycle, no done; a following start with length=2 transfers normally from addr 0.

Source files
------------

// File: rtl/ioctl_stream_tx.sv
// Byte-stream to 16-bit ioctl word writer with download framing, pacing and abort.
// Optional checksum output enabled by defining IOCTL_STREAM_TX_CHECKSUM_EN.
module ioctl_stream_tx #(
  parameter int unsigned MIN_GAP  = 2,
  parameter logic [7:0]  PAD_BYTE = 8'hFF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [24:0] length,
  input  logic        src_valid,
  input  logic [7:0]  src_data,
  output logic        src_ready,
  output logic        ioctl_download,
  output logic        ioctl_wr,
  output logic [24:0] ioctl_addr,
  output logic [15:0] ioctl_dout,
  input  logic        ioctl_wait,
  output logic        busy,
  output logic        done,
  output logic        aborted
`ifdef IOCTL_STREAM_TX_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  localparam int unsigned GMAX = (MIN_GAP < 1) ? 1 : MIN_GAP;
  localparam int unsigned GW   = $clog2(GMAX + 1);
  localparam logic [GW-1:0] GAP_MIN = GW'(MIN_GAP);

  typedef enum logic [2:0] {IDLE, FILL_LO, FILL_HI, WRITE, HOLD, TAIL} state_t;

  state_t        state_q;
  logic [24:0]   cnt_q, addr_q;
  logic [15:0]   dout_q;
  logic          dl_q, wr_q, done_q, aborted_q, abort_pend_q, first_q, tail_q;
  logic [GW-1:0] gap_q;
  logic [24:0]   cnt_d;
  logic          take, hold_exit;

  // An abort in a fill state wins over a byte offered in the same cycle.
  assign src_ready = ((state_q == FILL_LO) || (state_q == FILL_HI)) && !abort;
  assign take      = src_valid && src_ready;
  assign hold_exit = (gap_q >= GAP_MIN) && (first_q || !ioctl_wait);
  assign cnt_d     = (cnt_q > 25'd2) ? (cnt_q - 25'd2) : '0;

  assign ioctl_download = dl_q;
  assign ioctl_wr       = wr_q;
  assign ioctl_addr     = addr_q;
  assign ioctl_dout     = dout_q;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign aborted        = aborted_q;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      dout_q       <= '0;
      dl_q         <= 1'b0;
      wr_q         <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      first_q      <= 1'b0;
      tail_q       <= 1'b0;
      gap_q        <= '0;
    end else begin
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q        <= length;
            addr_q       <= '0;
            dl_q         <= 1'b1;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            state_q      <= (length == '0) ? TAIL : FILL_LO;
          end
        end
        FILL_LO: begin
          if (abort) begin
            aborted_q <= 1'b1;
            state_q   <= TAIL;
          end else if (take) begin
            dout_q[7:0] <= src_data;
            if (cnt_q == 25'd1) begin
              dout_q[15:8] <= PAD_BYTE;
              wr_q         <= 1'b1;
              state_q      <= WRITE;
            end else begin
              state_q <= FILL_HI;
            end
          end
        end
        FILL_HI: begin
          if (abort) begin
            aborted_q <= 1'b1;
            state_q   <= TAIL;
          end else if (take) begin
            dout_q[15:8] <= src_data;
            wr_q         <= 1'b1;
            state_q      <= WRITE;
          end
        end
        WRITE: begin
          gap_q   <= GW'(1);
          first_q <= 1'b1;
          if (abort) abort_pend_q <= 1'b1;
          state_q <= HOLD;
        end
        HOLD: begin
          first_q <= 1'b0;
          if (gap_q < GAP_MIN) gap_q <= gap_q + GW'(1);
          if (abort) abort_pend_q <= 1'b1;
          if (hold_exit) begin
            addr_q <= addr_q + 25'd2;
            cnt_q  <= cnt_d;
            if ((cnt_d == '0) || abort_pend_q || abort) begin
              aborted_q <= abort_pend_q || abort;
              state_q   <= TAIL;
            end else begin
              state_q <= FILL_LO;
            end
          end
        end
        TAIL: begin
          if (!tail_q) begin
            tail_q <= 1'b1;
          end else begin
            tail_q  <= 1'b0;
            dl_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef IOCTL_STREAM_TX_CHECKSUM_EN
  logic [15:0] csum_q;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      csum_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      csum_q <= '0;
    end else if (take) begin
      csum_q <= csum_q + {8'h00, src_data};
    end
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_ioctl_stream_tx.sv
// Directed self-checking bench for ioctl_stream_tx (define IOCTL_STREAM_TX_CHECKSUM_EN to check checksum).
module tb_ioctl_stream_tx;

  logic        clk_sys = 1'b0;
  logic        reset_n, start, abort, src_valid, ioctl_wait;
  logic [24:0] length;
  logic [7:0]  src_data;
  logic        src_ready, ioctl_download, ioctl_wr, busy, done, aborted;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_dout;
`ifdef IOCTL_STREAM_TX_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  ioctl_stream_tx #(.MIN_GAP(2), .PAD_BYTE(8'hFF)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .abort(abort),
    .length(length), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .busy(busy), .done(done), .aborted(aborted)
`ifdef IOCTL_STREAM_TX_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0, passed = 0, fails = 0;
  logic [7:0]  src_mem [16];
  logic [24:0] wr_addr [4];
  logic [15:0] wr_dout [4];
  int          wr_cyc  [4];
  int wr_n, done_n, dl_cycles, taken, stab_err, timed_out, ab_seen, done_after_rst;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int len, input int abort_after, input int wait_len, input int restart_at);
    int c, extra, first_wr;
    bit seen_done;
    wr_n = 0; done_n = 0; dl_cycles = 0; taken = 0; stab_err = 0; ab_seen = 0;
    first_wr = -1; c = 0; extra = 0; seen_done = 0;
    length = 25'(len); start = 1'b1; src_valid = 1'b0; abort = 1'b0; ioctl_wait = 1'b0;
    while (extra < 3 && c < 300) begin
      @(negedge clk_sys);
      if (ioctl_download) dl_cycles++;
      if (ioctl_wr) begin
        if (wr_n < 4) begin
          wr_addr[wr_n] = ioctl_addr; wr_dout[wr_n] = ioctl_dout; wr_cyc[wr_n] = c;
        end
        wr_n++;
        if (first_wr < 0) first_wr = c;
      end
      if (first_wr >= 0 && c > first_wr && c <= first_wr + wait_len + 1 &&
          (ioctl_dout !== wr_dout[0] || ioctl_addr !== wr_addr[0])) stab_err++;
      if (done) begin done_n++; ab_seen = int'(aborted); seen_done = 1; end
      if (src_valid && src_ready) taken++;
      if (seen_done) extra++;
      @(posedge clk_sys); #1;
      c++;
      start = (c == restart_at);
      if (c == restart_at) length = '0;
      src_valid  = (taken < len);
      src_data   = (taken < 16) ? src_mem[taken] : 8'h00;
      abort      = (abort_after >= 0 && taken == abort_after);
      ioctl_wait = (first_wr >= 0 && c > first_wr && c <= first_wr + wait_len);
    end
    timed_out = seen_done ? 0 : 1;
    start = 1'b0; abort = 1'b0; ioctl_wait = 1'b0; src_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; length = '0;
    src_valid = 1'b0; src_data = '0; ioctl_wait = 1'b0;
    for (int i = 0; i < 16; i++) src_mem[i] = 8'(i + 1);
    repeat (2) @(posedge clk_sys);
    #1;
    check("rst_download", ioctl_download, 0);
    check("rst_wr", ioctl_wr, 0);
    check("rst_addr", ioctl_addr, 0);
    check("rst_dout", ioctl_dout, 0);
    check("rst_src_ready", src_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    reset_n = 1'b1;
    @(posedge clk_sys); #1;

    // four bytes, no wait
    src_mem[0] = 8'h11; src_mem[1] = 8'h22; src_mem[2] = 8'h33; src_mem[3] = 8'h44;
    run(4, -1, 0, -1);
    check("l4_timeout", timed_out, 0);
    check("l4_wr_n", wr_n, 2);
    check("l4_addr0", wr_addr[0], 25'd0);
    check("l4_dout0", wr_dout[0], 16'h2211);
    check("l4_addr1", wr_addr[1], 25'd2);
    check("l4_dout1", wr_dout[1], 16'h4433);
    check("l4_done_n", done_n, 1);
    check("l4_aborted", ab_seen, 0);
    check("l4_gap_min", (wr_cyc[1] - wr_cyc[0]) >= 2, 1);
    check("l4_idle_dl", ioctl_download, 0);
    check("l4_idle_busy", busy, 0);

    // odd length with pad byte
    src_mem[0] = 8'hAA; src_mem[1] = 8'hBB; src_mem[2] = 8'hCC;
    run(3, -1, 0, -1);
    check("l3_timeout", timed_out, 0);
    check("l3_wr_n", wr_n, 2);
    check("l3_dout0", wr_dout[0], 16'hBBAA);
    check("l3_addr1", wr_addr[1], 25'd2);
    check("l3_dout1", wr_dout[1], 16'hFFCC);
`ifdef IOCTL_STREAM_TX_CHECKSUM_EN
    check("l3_checksum", checksum, 16'h0231);
`endif

    // receiver wait for 10 cycles after first write; stray start mid-transfer is ignored
    src_mem[0] = 8'h01; src_mem[1] = 8'h02; src_mem[2] = 8'h03; src_mem[3] = 8'h04;
    run(4, -1, 10, 5);
    check("wt_timeout", timed_out, 0);
    check("wt_wr_n", wr_n, 2);
    check("wt_gap_ge12", (wr_cyc[1] - wr_cyc[0]) >= 12, 1);
    check("wt_stable", stab_err, 0);
    check("wt_dout1", wr_dout[1], 16'h0403);
    check("wt_addr1", wr_addr[1], 25'd2);

    // zero length
    run(0, -1, 0, -1);
    check("l0_timeout", timed_out, 0);
    check("l0_dl_cycles", dl_cycles, 2);
    check("l0_wr_n", wr_n, 0);
    check("l0_done_n", done_n, 1);
    check("l0_aborted", ab_seen, 0);

    // abort in FILL_HI after 5 of 8 bytes
    for (int i = 0; i < 8; i++) src_mem[i] = 8'(8'h10 + i);
    run(8, 5, 0, -1);
    check("ab_timeout", timed_out, 0);
    check("ab_wr_n", wr_n, 2);
    check("ab_addr0", wr_addr[0], 25'd0);
    check("ab_addr1", wr_addr[1], 25'd2);
    check("ab_dout1", wr_dout[1], 16'h1312);
    check("ab_done_n", done_n, 1);
    check("ab_aborted", ab_seen, 1);

    // reset during HOLD, then a clean 2-byte transfer
    length = 25'd4; start = 1'b1; src_valid = 1'b1; src_data = 8'h77;
    @(posedge clk_sys); #1;
    start = 1'b0;
    begin
      int n;
      n = 0;
      while (!ioctl_wr && n < 20) begin @(posedge clk_sys); #1; n++; end
      check("rs_wr_seen", ioctl_wr, 1);
    end
    @(posedge clk_sys); #1;
    reset_n = 1'b0;
    @(posedge clk_sys); #1;
    reset_n = 1'b1; src_valid = 1'b0;
    check("rs_download", ioctl_download, 0);
    check("rs_busy", busy, 0);
    done_after_rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_sys);
      if (done) done_after_rst++;
    end
    check("rs_no_done", done_after_rst, 0);
    src_mem[0] = 8'h5A; src_mem[1] = 8'hA5;
    @(posedge clk_sys); #1;
    run(2, -1, 0, -1);
    check("rs2_timeout", timed_out, 0);
    check("rs2_wr_n", wr_n, 1);
    check("rs2_addr0", wr_addr[0], 25'd0);
    check("rs2_dout0", wr_dout[0], 16'hA55A);
    check("rs2_done_n", done_n, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
